fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_addsub_pipe.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract pipeline:
// default field widths, flag bit positions, operand classes and the
// canonical quiet-NaN pattern.
package fp_pkg;

   localparam int DEF_EXP_W = 8;
   localparam int DEF_MAN_W = 23;

   // flags = {invalid, overflow, inexact}
   localparam int FLAG_W        = 3;
   localparam int FLAG_INVALID  = 2;
   localparam int FLAG_OVERFLOW = 1;
   localparam int FLAG_INEXACT  = 0;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_NORMAL,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } fp_class_e;

   // Sign 0, exponent all ones, mantissa MSB set; caller truncates to its width
   function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
      logic [63:0] r;
      r = ((64'd1 << exp_w) - 64'd1) << man_w;
      r = r | (64'd1 << (man_w - 1));
      return r;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
)(
   input  logic [WIDTH-1:0] value,
   output logic [CNT_W-1:0] count
);

   // Highest set bit wins because later loop iterations overwrite earlier ones
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor with valid/ready
// handshake. S1 unpack/classify/swap, S2 align with guard/round/sticky,
// S3 add/sub plus leading-zero count, S4 normalise/round/pack/flags.
module fp_addsub_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = DEF_EXP_W,
   parameter int MAN_W = DEF_MAN_W,
   localparam int W = 1 + EXP_W + MAN_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      A,
   input  logic [W-1:0]      B,
   input  logic              op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      Sum,
   output logic [FLAG_W-1:0] flags
);

   localparam int XW        = MAN_W + 4;          // hidden + fraction + G/R/S
   localparam int NW        = MAN_W + 5;          // XW plus carry-out
   localparam int LZW       = $clog2(NW + 1);
   localparam int MR_W      = MAN_W + 2;          // rounded mantissa incl. carry
   localparam int SAT_SHIFT = MAN_W + 3;
   localparam int EXP_INF   = (1 << EXP_W) - 1;
   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [W-1:0]     QNAN    = W'(canon_nan(EXP_W, MAN_W));

   logic advance;
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
      fp_class_e c;
      c = CLS_NORMAL;
      if (e == '0)                c = CLS_ZERO;
      else if (e == EXP_MAX) begin
         if (m == '0)             c = CLS_INF;
         else if (m[MAN_W-1])     c = CLS_QNAN;
         else                     c = CLS_SNAN;
      end
      return c;
   endfunction

   // ---------------- S1: unpack, classify, order by magnitude ----------------
   fp_class_e           a_cls, b_cls;
   logic                sa, sb_eff, swap;
   logic [EXP_W-1:0]    a_e, b_e;
   logic [MAN_W:0]      a_m, b_m;
   logic                spec_hit;
   logic [W-1:0]        spec_word;
   logic [FLAG_W-1:0]   spec_flags;

   // Subnormals are treated as signed zero: exponent and mantissa cleared
   always_comb begin
      sa     = A[W-1];
      sb_eff = B[W-1] ^ op;
      a_cls  = classify(A[W-2:MAN_W], A[MAN_W-1:0]);
      b_cls  = classify(B[W-2:MAN_W], B[MAN_W-1:0]);
      a_e    = (a_cls == CLS_ZERO) ? '0 : A[W-2:MAN_W];
      b_e    = (b_cls == CLS_ZERO) ? '0 : B[W-2:MAN_W];
      a_m    = (a_cls == CLS_ZERO) ? '0 : {1'b1, A[MAN_W-1:0]};
      b_m    = (b_cls == CLS_ZERO) ? '0 : {1'b1, B[MAN_W-1:0]};
      swap   = {b_e, b_m} > {a_e, a_m};
   end

   // NaN / infinity outcomes are decided here and carried past the datapath
   always_comb begin
      spec_hit   = 1'b0;
      spec_word  = '0;
      spec_flags = '0;
      if (a_cls == CLS_QNAN || a_cls == CLS_SNAN || b_cls == CLS_QNAN || b_cls == CLS_SNAN) begin
         spec_hit                 = 1'b1;
         spec_word                = QNAN;
         spec_flags[FLAG_INVALID] = (a_cls == CLS_SNAN) || (b_cls == CLS_SNAN);
      end else if (a_cls == CLS_INF && b_cls == CLS_INF) begin
         spec_hit = 1'b1;
         if (sa != sb_eff) begin
            spec_word                = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
         end else begin
            spec_word = {sa, EXP_MAX, {MAN_W{1'b0}}};
         end
      end else if (a_cls == CLS_INF) begin
         spec_hit  = 1'b1;
         spec_word = {sa, EXP_MAX, {MAN_W{1'b0}}};
      end else if (b_cls == CLS_INF) begin
         spec_hit  = 1'b1;
         spec_word = {sb_eff, EXP_MAX, {MAN_W{1'b0}}};
      end
   end

   logic                s1_valid_reg, s1_sx_reg, s1_sy_reg, s1_spec_reg;
   logic [EXP_W-1:0]    s1_ex_reg, s1_ey_reg;
   logic [MAN_W:0]      s1_mx_reg, s1_my_reg;
   logic [W-1:0]        s1_word_reg;
   logic [FLAG_W-1:0]   s1_flags_reg;

   // S1 register: X always holds the larger magnitude
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_reg <= 1'b0; s1_sx_reg <= 1'b0; s1_sy_reg <= 1'b0; s1_spec_reg <= 1'b0;
         s1_ex_reg <= '0; s1_ey_reg <= '0; s1_mx_reg <= '0; s1_my_reg <= '0;
         s1_word_reg <= '0; s1_flags_reg <= '0;
      end else if (advance) begin
         s1_valid_reg <= in_valid;
         s1_sx_reg    <= swap ? sb_eff : sa;
         s1_sy_reg    <= swap ? sa : sb_eff;
         s1_ex_reg    <= swap ? b_e : a_e;
         s1_ey_reg    <= swap ? a_e : b_e;
         s1_mx_reg    <= swap ? b_m : a_m;
         s1_my_reg    <= swap ? a_m : b_m;
         s1_spec_reg  <= spec_hit;
         s1_word_reg  <= spec_word;
         s1_flags_reg <= spec_flags;
      end
   end

   // ---------------- S2: align Y ----------------
   logic [31:0]   diff;
   logic [XW-1:0] y_ext, y_sh, y_al;
   logic          y_lost;

   // Shifts of MAN_W+3 or more leave only the sticky bit
   always_comb begin
      diff   = 32'(s1_ex_reg) - 32'(s1_ey_reg);
      y_ext  = {s1_my_reg, 3'b000};
      y_sh   = '0;
      y_lost = 1'b0;
      y_al   = '0;
      if (diff >= 32'(SAT_SHIFT)) begin
         y_al = {{(XW-1){1'b0}}, |s1_my_reg};
      end else begin
         y_sh   = y_ext >> diff;
         y_lost = |(y_ext & ~({XW{1'b1}} << diff));
         y_al   = {y_sh[XW-1:1], y_sh[0] | y_lost};
      end
   end

   logic                s2_valid_reg, s2_sx_reg, s2_sub_reg, s2_spec_reg;
   logic [EXP_W-1:0]    s2_ex_reg;
   logic [MAN_W:0]      s2_mx_reg;
   logic [XW-1:0]       s2_yal_reg;
   logic [W-1:0]        s2_word_reg;
   logic [FLAG_W-1:0]   s2_flags_reg;

   // S2 register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid_reg <= 1'b0; s2_sx_reg <= 1'b0; s2_sub_reg <= 1'b0; s2_spec_reg <= 1'b0;
         s2_ex_reg <= '0; s2_mx_reg <= '0; s2_yal_reg <= '0;
         s2_word_reg <= '0; s2_flags_reg <= '0;
      end else if (advance) begin
         s2_valid_reg <= s1_valid_reg;
         s2_sx_reg    <= s1_sx_reg;
         s2_sub_reg   <= s1_sx_reg ^ s1_sy_reg;
         s2_spec_reg  <= s1_spec_reg;
         s2_ex_reg    <= s1_ex_reg;
         s2_mx_reg    <= s1_mx_reg;
         s2_yal_reg   <= y_al;
         s2_word_reg  <= s1_word_reg;
         s2_flags_reg <= s1_flags_reg;
      end
   end

   // ---------------- S3: add/subtract, leading zeros ----------------
   logic [NW-1:0]  raw_sum;
   logic [LZW-1:0] raw_lz;

   // |X| >= |Y| so the difference can never go negative
   always_comb begin
      raw_sum = s2_sub_reg ? ({1'b0, s2_mx_reg, 3'b000} - {1'b0, s2_yal_reg})
                           : ({1'b0, s2_mx_reg, 3'b000} + {1'b0, s2_yal_reg});
   end

   fp_lzc #(.WIDTH(NW)) u_lzc (
      .value (raw_sum),
      .count (raw_lz)
   );

   logic                s3_valid_reg, s3_sign_reg, s3_zero_reg, s3_spec_reg;
   logic [EXP_W-1:0]    s3_ex_reg;
   logic [NW-1:0]       s3_sum_reg;
   logic [LZW-1:0]      s3_lz_reg;
   logic [W-1:0]        s3_word_reg;
   logic [FLAG_W-1:0]   s3_flags_reg;

   // S3 register: an exact-zero difference is +0, a same-sign zero keeps its sign
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s3_valid_reg <= 1'b0; s3_sign_reg <= 1'b0; s3_zero_reg <= 1'b0; s3_spec_reg <= 1'b0;
         s3_ex_reg <= '0; s3_sum_reg <= '0; s3_lz_reg <= '0;
         s3_word_reg <= '0; s3_flags_reg <= '0;
      end else if (advance) begin
         s3_valid_reg <= s2_valid_reg;
         s3_zero_reg  <= (raw_sum == '0);
         s3_sign_reg  <= (raw_sum == '0 && s2_sub_reg) ? 1'b0 : s2_sx_reg;
         s3_spec_reg  <= s2_spec_reg;
         s3_ex_reg    <= s2_ex_reg;
         s3_sum_reg   <= raw_sum;
         s3_lz_reg    <= raw_lz;
         s3_word_reg  <= s2_word_reg;
         s3_flags_reg <= s2_flags_reg;
      end
   end

   // ---------------- S4: normalise, round, pack ----------------
   logic [NW-1:0]     norm;
   logic              guard, sticky, round_up;
   logic [MR_W-1:0]   mant_r;
   logic [MAN_W-1:0]  frac;
   int                e_res;
   logic [W-1:0]      res_word;
   logic [FLAG_W-1:0] res_flags;

   // Round-to-nearest-even; a rounding carry bumps the exponent by one
   always_comb begin
      norm      = s3_sum_reg << s3_lz_reg;
      guard     = norm[3];
      sticky    = |norm[2:0];
      round_up  = guard & (sticky | norm[4]);
      mant_r    = {1'b0, norm[NW-1:4]} + MR_W'(round_up);
      e_res     = int'(s3_ex_reg) + 1 - int'(s3_lz_reg) + int'(mant_r[MAN_W+1]);
      frac      = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
      res_word  = '0;
      res_flags = '0;
      if (s3_spec_reg) begin
         res_word  = s3_word_reg;
         res_flags = s3_flags_reg;
      end else if (s3_zero_reg) begin
         res_word = {s3_sign_reg, {(W-1){1'b0}}};
      end else if (e_res >= EXP_INF) begin
         res_word                  = {s3_sign_reg, EXP_MAX, {MAN_W{1'b0}}};
         res_flags[FLAG_OVERFLOW]  = 1'b1;
         res_flags[FLAG_INEXACT]   = 1'b1;
      end else if (e_res <= 0) begin
         res_word                 = {s3_sign_reg, {(W-1){1'b0}}};
         res_flags[FLAG_INEXACT]  = 1'b1;
      end else begin
         res_word                 = {s3_sign_reg, e_res[EXP_W-1:0], frac};
         res_flags[FLAG_INEXACT]  = guard | sticky;
      end
   end

   // Output register: Sum/flags hold while the consumer stalls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         Sum       <= '0;
         flags     <= '0;
      end else if (advance) begin
         out_valid <= s3_valid_reg;
         Sum       <= res_word;
         flags     <= res_flags;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single precision plus a half-precision
// instance, covering latency, rounding, specials, backpressure and reset.
module tb_fp_addsub_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid, in_ready, op, out_valid, out_ready;
   logic [31:0] A, B, Sum;
   logic [2:0]  flags;

   logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
   logic [15:0] h_a, h_b, h_sum;
   logic [2:0]  h_flags;

   int checks = 0;
   int fails  = 0;

   fp_addsub_pipe u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .Sum(Sum), .flags(flags)
   );

   fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_half (
      .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
      .A(h_a), .B(h_b), .op(h_op), .out_valid(h_out_valid), .out_ready(h_out_ready),
      .Sum(h_sum), .flags(h_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One isolated operation with out_ready high; checks latency, Sum, flags
   task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input logic [31:0] es, input logic [2:0] ef);
      int n;
      @(negedge clk);
      A = a; B = b; op = o; in_valid = 1'b1;
      @(posedge clk);
      n = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && n < 12) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check({tag, "_lat"},   64'(n),     64'd4);
      check({tag, "_sum"},   64'(Sum),   64'(es));
      check({tag, "_flags"}, 64'(flags), 64'(ef));
   endtask

   task automatic run_half(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] es, input logic [2:0] ef);
      int n;
      @(negedge clk);
      h_a = a; h_b = b; h_op = 1'b0; h_in_valid = 1'b1;
      @(posedge clk);
      n = 1;
      @(negedge clk);
      h_in_valid = 1'b0;
      while (!h_out_valid && n < 12) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check({tag, "_lat"},   64'(n),       64'd4);
      check({tag, "_sum"},   64'(h_sum),   64'(es));
      check({tag, "_flags"}, 64'(h_flags), 64'(ef));
   endtask

   logic [31:0] bp_a [8];
   logic [31:0] bp_b [8];
   logic        bp_op [8];
   logic [31:0] bp_exp [8];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int in_idx, out_idx, stale;
      logic prev_stall;
      logic [31:0] prev_sum;

      bp_a   = '{32'h3F800000, 32'h40400000, 32'h40800000, 32'h3F000000,
                 32'h41200000, 32'h40000000, 32'hC0000000, 32'h3F800000};
      bp_b   = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F000000,
                 32'h41200000, 32'h40400000, 32'h3F800000, 32'hBF800000};
      bp_op  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      bp_exp = '{32'h40400000, 32'h40800000, 32'h40400000, 32'h3F800000,
                 32'h41A00000, 32'hBF800000, 32'hBF800000, 32'h00000000};

      clk = 1'b0; reset = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; A = '0; B = '0;
      h_in_valid = 1'b0; h_out_ready = 1'b1; h_op = 1'b0; h_a = '0; h_b = '0;

      // Reset state, with out_ready low to show in_ready does not depend on it
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_sum",       64'(Sum),       64'd0);
      check("rst_flags",     64'(flags),     64'd0);

      // Back-to-back stream, first accept on the first edge after release
      out_ready = 1'b1;
      reset = 1'b0;
      A = 32'h3F800000; B = 32'h40000000; op = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      A = 32'h4F000000; B = 32'h4F000000;
      check("b2b_lat_e1", 64'(out_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      A = 32'h00000000; B = 32'h3F800000;
      check("b2b_lat_e2", 64'(out_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      A = 32'h3E800000; B = 32'h3E800000;
      check("b2b_lat_e3", 64'(out_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_valid0", 64'(out_valid), 64'd1);
      check("b2b_sum0",   64'(Sum),       64'h40400000);
      check("b2b_flags0", 64'(flags),     64'd0);
      @(negedge clk);
      check("b2b_valid1", 64'(out_valid), 64'd1);
      check("b2b_sum1",   64'(Sum),       64'h4F800000);
      @(negedge clk);
      check("b2b_valid2", 64'(out_valid), 64'd1);
      check("b2b_sum2",   64'(Sum),       64'h3F800000);
      @(negedge clk);
      check("b2b_valid3", 64'(out_valid), 64'd1);
      check("b2b_sum3",   64'(Sum),       64'h3F000000);
      @(negedge clk);
      check("b2b_drain",  64'(out_valid), 64'd0);

      // Subtraction, specials, rounding
      run_one("sub_zero",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
      run_one("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
      run_one("ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
      run_one("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
      run_one("tie_up",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
      run_one("qnan_in",   32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
      run_one("snan_in",   32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 3'b100);
      run_one("inf_fin",   32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b000);
      run_one("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
      run_one("underflow", 32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001);
      run_one("far_align", 32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b001);

      // Backpressure: random out_ready with a forced 5-cycle stall
      in_idx = 0; out_idx = 0; prev_stall = 1'b0; prev_sum = '0;
      for (int cyc = 0; cyc < 300 && out_idx < 8; cyc++) begin
         @(negedge clk);
         if (prev_stall) begin
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_sum",   64'(Sum),       64'(prev_sum));
         end
         out_ready = (cyc >= 6 && cyc < 11) ? 1'b0 : 1'($urandom_range(0, 1));
         in_valid  = (in_idx < 8);
         if (in_idx < 8) begin
            A = bp_a[in_idx]; B = bp_b[in_idx]; op = bp_op[in_idx];
         end
         #1;
         if (out_valid && !out_ready) check("bp_full_in_ready", 64'(in_ready), 64'd0);
         if (out_valid && out_ready) begin
            check($sformatf("bp_sum%0d", out_idx),   64'(Sum),   64'(bp_exp[out_idx]));
            check($sformatf("bp_flags%0d", out_idx), 64'(flags), 64'd0);
            out_idx++;
         end
         if (in_valid && in_ready) in_idx++;
         prev_stall = out_valid && !out_ready;
         prev_sum   = Sum;
      end
      check("bp_count", 64'(out_idx), 64'd8);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) @(negedge clk);

      // Reset mid-stream with one result showing and three in flight
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1; A = bp_a[i]; B = bp_b[i]; op = bp_op[i];
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_pre_valid", 64'(out_valid), 64'd1);
      reset = 1'b1;
      #1;
      check("mid_valid", 64'(out_valid), 64'd0);
      check("mid_sum",   64'(Sum),       64'd0);
      check("mid_ready", 64'(in_ready),  64'd1);
      @(negedge clk);
      reset = 1'b0;
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("mid_no_stale", 64'(stale), 64'd0);
      run_one("mid_next", 32'h3E800000, 32'h3E800000, 1'b0, 32'h3F000000, 3'b000);

      // Half-precision instance
      run_half("h_add", 16'h3C00, 16'h4000, 16'h4200, 3'b000);
      run_half("h_ovf", 16'h7BFF, 16'h7BFF, 16'h7C00, 3'b011);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
